// File: rtl/uart_tx_result_ctrl.sv
// Captures an ALU result on trigger and ships it byte by byte to a UART TX core
// through its start/busy handshake, with a settle delay before each start pulse.
module uart_tx_result_ctrl #(
    parameter int unsigned DATA_WIDTH              = 16,
    parameter bit          LSB_FIRST               = 1'b1,
    parameter int unsigned WAIT_FOR_REGISTER_DELAY = 100,
    parameter int unsigned BUSY_RISE_TIMEOUT       = 64
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  trigger,
    input  logic [DATA_WIDTH-1:0] result,
    input  logic                  tx_busy,
    output logic                  tx_start,
    output logic [7:0]            tx_data,
    output logic                  busy,
    output logic                  done,
    output logic                  overrun,
    output logic [3:0]            LED
);

    localparam int unsigned NB       = DATA_WIDTH / 8;
    // A zero delay or timeout behaves as a single cycle.
    localparam int unsigned HOLD_CYC = (WAIT_FOR_REGISTER_DELAY == 0) ? 1 : WAIT_FOR_REGISTER_DELAY;
    localparam int unsigned RISE_CYC = (BUSY_RISE_TIMEOUT == 0) ? 1 : BUSY_RISE_TIMEOUT;
    localparam int unsigned MAX_CYC  = (HOLD_CYC > RISE_CYC) ? HOLD_CYC : RISE_CYC;
    localparam int unsigned TW       = $clog2(MAX_CYC + 1);
    localparam int unsigned IW       = (NB > 1) ? $clog2(NB) : 1;

    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYC - 1);
    localparam logic [TW-1:0] RISE_LAST = TW'(RISE_CYC - 1);
    localparam logic [IW-1:0] IDX_LAST  = IW'(NB - 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_LOAD    = 3'd1,
        S_HOLD    = 3'd2,
        S_SEND    = 3'd3,
        S_WAIT_HI = 3'd4,
        S_WAIT_LO = 3'd5,
        S_NEXT    = 3'd6,
        S_DONE    = 3'd7
    } state_e;

    state_e                state_q,    state_d;
    logic [IW-1:0]         idx_q,      idx_d;
    logic [TW-1:0]         timer_q,    timer_d;
    logic [DATA_WIDTH-1:0] capture_q,  capture_d;
    logic [7:0]            tx_data_q,  tx_data_d;
    logic                  tx_start_q, tx_start_d;
    logic                  busy_q,     busy_d;
    logic                  done_q,     done_d;
    logic                  overrun_q,  overrun_d;
    logic [7:0]            byte_sel;

    // Byte idx of the captured word in transmission order.
    always_comb begin
        byte_sel = '0;
        for (int unsigned k = 0; k < NB; k++) begin
            if (idx_q == IW'(k)) begin
                byte_sel = LSB_FIRST ? capture_q[8*k +: 8] : capture_q[8*(NB-1-k) +: 8];
            end
        end
    end

    // Next-state and registered-output decode.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        timer_d   = timer_q;
        capture_d = capture_q;
        tx_data_d = tx_data_q;

        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    capture_d = result;
                    idx_d     = '0;
                    state_d   = S_LOAD;
                end
            end
            S_LOAD: begin
                tx_data_d = byte_sel;
                timer_d   = '0;
                state_d   = S_HOLD;
            end
            S_HOLD: begin
                if (timer_q == HOLD_LAST) begin
                    state_d = S_SEND;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_SEND: begin
                timer_d = '0;
                state_d = S_WAIT_HI;
            end
            S_WAIT_HI: begin
                if (tx_busy) begin
                    state_d = S_WAIT_LO;
                end else if (timer_q == RISE_LAST) begin
                    state_d = S_NEXT;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            S_WAIT_LO: begin
                if (!tx_busy) begin
                    state_d = S_NEXT;
                end
            end
            S_NEXT: begin
                if (idx_q == IDX_LAST) begin
                    state_d = S_DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = S_LOAD;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        tx_start_d = (state_d == S_SEND);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
        overrun_d  = trigger && busy_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            idx_q      <= '0;
            timer_q    <= '0;
            capture_q  <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            timer_q    <= timer_d;
            capture_q  <= capture_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign overrun  = overrun_q;
    assign LED      = {1'b0, state_q};

endmodule
